// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and constants for the CPU run monitor and its stimulus ROMs.
package cpu_tb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PASS,
    FAIL,
    TIMEOUT
  } run_state_t;

  // Boot address of the CPU under test; stimulus ROMs are laid out from here.
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  // PASS, FAIL and TIMEOUT hold until reset.
  function automatic logic is_terminal(input run_state_t s);
    return (s == PASS) || (s == FAIL) || (s == TIMEOUT);
  endfunction

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Observation bundle of the CPU under test: run flag, fetch address and $v0.
interface cpu_run_monitor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              active;
  logic [ADDR_W-1:0] instr_address;
  logic [DATA_W-1:0] register_v0;

  // The CPU (or a stimulus model) drives the bundle.
  modport master (
    output active,
    output instr_address,
    output register_v0
  );

  // The monitor only observes.
  modport slave (
    input active,
    input instr_address,
    input register_v0
  );

endinterface

// File: rtl/cpu_run_monitor_trace_ring_buffer.sv
// Ring buffer of the last DEPTH fetch addresses, read newest-relative.
module trace_ring_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [ADDR_W-1:0]          rd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Write at the pointer, wrap modulo DEPTH, saturate the valid count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= data;
      wr_ptr      <= wr_ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Index 0 is the entry just behind the write pointer; unwritten slots read 0.
  always_comb begin
    rd_ptr  = wr_ptr - PTR_W'(1) - rd_idx;
    rd_data = '0;
    if (CNT_W'(rd_idx) < count) begin
      rd_data = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor for mips_cpu_harvard benches: halt detection, v0 check,
// cycle timeout and a fetch-address trace.
module cpu_run_monitor
  import cpu_tb_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR      = '0,
  parameter int unsigned       TIMEOUT_CYCLES = 1000,
  parameter int unsigned       DEPTH          = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clk_enable,
  cpu_run_monitor_if.slave                      cpu,
  input  logic [DATA_W-1:0]                     expected_v0,
  output logic                                  done,
  output logic                                  pass,
  output logic                                  fail,
  output logic                                  timeout,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]   cycle_count,
  output logic [DATA_W-1:0]                     result_v0,
  output logic [$clog2(DEPTH+1)-1:0]            trace_count,
  input  logic [$clog2(DEPTH)-1:0]              trace_rd_idx,
  output logic [ADDR_W-1:0]                     trace_rd_data
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  run_state_t state;
  run_state_t state_next;

  logic halt_hit;
  logic v0_match;
  logic at_limit;
  logic push;
  logic count_load;
  logic count_inc;
  logic capture;

  // Halt / compare / limit conditions seen by the FSM this cycle.
  always_comb begin
    halt_hit = (cpu.instr_address == HALT_ADDR) || !cpu.active;
    v0_match = (cpu.register_v0 == expected_v0);
    at_limit = (cycle_count == CNT_W'(TIMEOUT_CYCLES));
  end

  // State register; reset wins over clk_enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_enable) begin
      state <= state_next;
    end
  end

  // Next-state logic; halt takes precedence over timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu.active) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (halt_hit) begin
          state_next = v0_match ? PASS : FAIL;
        end else if (at_limit) begin
          state_next = TIMEOUT;
        end
      end
      default: state_next = state;
    endcase
  end

  // Status decode and datapath strobes, all gated by clk_enable.
  always_comb begin
    done       = is_terminal(state);
    pass       = (state == PASS);
    fail       = (state == FAIL);
    timeout    = (state == TIMEOUT);
    push       = 1'b0;
    count_load = 1'b0;
    count_inc  = 1'b0;
    capture    = 1'b0;
    if (clk_enable) begin
      case (state)
        IDLE: begin
          if (cpu.active) begin
            push       = 1'b1;
            count_load = 1'b1;
          end
        end
        RUN: begin
          if (halt_hit) begin
            push    = 1'b1;
            capture = 1'b1;
          end else if (!at_limit) begin
            push      = 1'b1;
            count_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Run-cycle counter and v0 capture at halt.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      result_v0   <= '0;
    end else begin
      if (count_load) begin
        cycle_count <= CNT_W'(1);
      end else if (count_inc) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      if (capture) begin
        result_v0 <= cpu.register_v0;
      end
    end
  end

  trace_ring_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_trace (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .data    (cpu.instr_address),
    .count   (trace_count),
    .rd_idx  (trace_rd_idx),
    .rd_data (trace_rd_data)
  );

endmodule
